// File: rtl/scale_mul_arbiter_if.sv
// Handshake bundle shared by the Y/U/V scaling lanes, the multiplier arbiter
// and the pipelined 32x32 multiplier it time-shares.
interface scale_mul_arbiter_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*32-1:0] req_a;
  logic [N_REQ*32-1:0] req_b;
  logic [N_REQ-1:0]    rsp_valid;
  logic [N_REQ-1:0]    rsp_ready;
  logic [N_REQ*32-1:0] rsp_data;
  logic                mul_ce;
  logic [31:0]         mul_din0;
  logic [31:0]         mul_din1;
  logic [31:0]         mul_dout;
  logic                busy;

  // The arbiter side; the lanes and the multiplier together form the master side.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_dout,
    output req_ready, rsp_valid, rsp_data, mul_ce, mul_din0, mul_din1, busy
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_dout,
    input  req_ready, rsp_valid, rsp_data, mul_ce, mul_din0, mul_din1, busy
  );
endinterface

// File: rtl/scale_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined 32x32 signed multiplier among N_REQ
// scaling lanes, returning each low-32-bit product through a per-lane response slot.
module scale_mul_arbiter #(
  parameter int N_REQ   = 3,
  parameter int MUL_LAT = 1
) (
  input logic                clk,
  input logic                reset,
  scale_mul_arbiter_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  typedef logic [IW-1:0] lane_t;

  logic [N_REQ-1:0]   outstanding;
  lane_t              last;
  logic [MUL_LAT-1:0] trk_vld;
  lane_t              trk_id [MUL_LAT];
  logic [N_REQ-1:0]   rsp_valid_q;
  logic [31:0]        rsp_data_q [N_REQ];

  logic [N_REQ-1:0]   eligible;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   drain;
  logic [N_REQ-1:0]   capture;
  logic               issue;
  lane_t              gnt_id;

  // A lane with an operation in flight or parked in its slot may not issue again.
  assign eligible = bus.req_valid & ~outstanding;
  assign drain    = rsp_valid_q & bus.rsp_ready;

  always_comb begin
    int idx;
    grant  = '0;
    gnt_id = '0;
    issue  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!issue && eligible[idx]) begin
        issue       = 1'b1;
        gnt_id      = lane_t'(idx);
        grant[idx]  = 1'b1;
      end
    end
    if (!reset) begin
      grant  = '0;
      gnt_id = '0;
      issue  = 1'b0;
    end
  end

  always_comb begin
    capture = '0;
    for (int i = 0; i < N_REQ; i++) begin
      capture[i] = trk_vld[MUL_LAT-1] && (trk_id[MUL_LAT-1] == lane_t'(i));
    end
  end

  always_comb begin
    bus.mul_din0 = '0;
    bus.mul_din1 = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        bus.mul_din0 = bus.req_a[i*32 +: 32];
        bus.mul_din1 = bus.req_b[i*32 +: 32];
      end
    end
  end

  // Once anything is in flight the multiplier is clocked every cycle, fixing the latency.
  assign bus.req_ready = grant;
  assign bus.mul_ce    = reset & (issue | (|trk_vld));
  assign bus.busy      = reset & (|outstanding);
  assign bus.rsp_valid = rsp_valid_q;

  always_comb begin
    bus.rsp_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.rsp_data[i*32 +: 32] = rsp_data_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      outstanding <= '0;
      last        <= lane_t'(N_REQ - 1);
    end else begin
      outstanding <= (outstanding & ~drain) | grant;
      if (issue) begin
        last <= gnt_id;
      end
    end
  end

  // Tracking pipe mirrors the multiplier stages so the product finds its owner.
  always_ff @(posedge clk) begin
    if (!reset) begin
      trk_vld <= '0;
      for (int s = 0; s < MUL_LAT; s++) begin
        trk_id[s] <= '0;
      end
    end else if (bus.mul_ce) begin
      trk_vld[0] <= issue;
      trk_id[0]  <= gnt_id;
      for (int s = 1; s < MUL_LAT; s++) begin
        trk_vld[s] <= trk_vld[s-1];
        trk_id[s]  <= trk_id[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid_q <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        rsp_data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (capture[i]) begin
          rsp_valid_q[i] <= 1'b1;
          rsp_data_q[i]  <= bus.mul_dout;
        end else if (drain[i]) begin
          rsp_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  // Structural invariants: single grant, no re-grant of a busy lane, no slot overwrite.
  a_grant_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(grant));
  a_grant_free:   assert property (@(posedge clk) disable iff (!reset) (grant & outstanding) == '0);
  a_slot_free:    assert property (@(posedge clk) disable iff (!reset) (capture & rsp_valid_q) == '0);

endmodule
